lfsr_bist_ctrl: RTL



---
 rtl/dft_pkg.sv | 15 +
 rtl/lfsr_bist_ctrl_if.sv | 32 +++
 rtl/misr_w.sv | 35 +++
 rtl/lfsr_bist_ctrl.sv | 93 +++++++++
 4 files changed

// File: rtl/dft_pkg.sv
// Shared DFT definitions: BIST sequencer states and default MISR geometry.
package dft_pkg;

  localparam int DFT_W = 5;
  localparam logic [DFT_W-1:0] DFT_POLY = 5'b00101;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    INIT = 3'd1,
    RUN  = 3'd2,
    CMP  = 3'd3,
    DONE = 3'd4
  } bist_state_e;

endpackage

// File: rtl/lfsr_bist_ctrl_if.sv
// Signal bundle between the test-mode top level (master) and the BIST controller (slave).
interface lfsr_bist_ctrl_if
  import dft_pkg::*;
#(
  parameter int W = DFT_W
) ();

  // No ready/valid pair: start is a single-cycle request that is only honoured
  // while the controller is idle or done; busy/done/pass/signature report status.
  logic        start;
  logic        abort;
  logic [W-1:0] golden_sig;
  logic [W-1:0] cut_resp;
  logic        lfsr_clr;
  logic        lfsr_enb;
  logic        busy;
  logic        done;
  logic        pass;
  logic [W-1:0] signature;
  bist_state_e state;

  modport master (
    output start, abort, golden_sig, cut_resp,
    input  lfsr_clr, lfsr_enb, busy, done, pass, signature, state
  );

  modport slave (
    input  start, abort, golden_sig, cut_resp,
    output lfsr_clr, lfsr_enb, busy, done, pass, signature, state
  );

endinterface

// File: rtl/misr_w.sv
// W-bit multiple-input signature register: shift left, fold MSB through POLY, XOR response in.
module misr_w
  import dft_pkg::*;
#(
  parameter int           W    = DFT_W,
  parameter logic [W-1:0] POLY = DFT_POLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d_in,
  output logic [W-1:0] sig
);

  logic [W-1:0] r_sig;
  logic [W-1:0] w_next;

  always_comb begin
    w_next = {r_sig[W-2:0], 1'b0} ^ (r_sig[W-1] ? POLY : '0) ^ d_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sig <= '0;
    end else if (clr) begin
      r_sig <= '0;
    end else if (en) begin
      r_sig <= w_next;
    end
  end

  assign sig = r_sig;

endmodule

// File: rtl/lfsr_bist_ctrl.sv
// BIST sequencer: clears and steps the pattern LFSR, compacts CUT responses, compares the signature.
module lfsr_bist_ctrl
  import dft_pkg::*;
#(
  parameter int           W          = DFT_W,
  parameter int           N_PATTERNS = 31,
  parameter logic [W-1:0] POLY       = DFT_POLY
) (
  input  logic              clk,
  input  logic              reset,
  lfsr_bist_ctrl_if.slave   bus
);

  localparam logic [15:0] LAST_COUNT = 16'(N_PATTERNS - 1);

  bist_state_e  r_state;
  logic [15:0]  r_count;
  logic         r_start;
  logic         r_pass;
  logic [W-1:0] w_sig;
  logic         w_misr_clr;
  logic         w_misr_en;

  // An abort in RUN must leave the signature as it was, so it also gates the MISR step.
  assign w_misr_clr = (r_state == INIT);
  assign w_misr_en  = (r_state == RUN) && !bus.abort;

  misr_w #(
    .W    (W),
    .POLY (POLY)
  ) u_misr (
    .clk   (clk),
    .reset (reset),
    .clr   (w_misr_clr),
    .en    (w_misr_en),
    .d_in  (bus.cut_resp),
    .sig   (w_sig)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
      r_start <= 1'b0;
      r_pass  <= 1'b0;
    end else begin
      // Start is captured only when a new run may begin, so pulses while busy are dropped.
      r_start <= bus.start && ((r_state == IDLE) || (r_state == DONE));
      case (r_state)
        IDLE: begin
          if (r_start) r_state <= INIT;
        end
        INIT: begin
          r_count <= '0;
          r_state <= bus.abort ? IDLE : RUN;
        end
        RUN: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else begin
            r_count <= r_count + 16'd1;
            if (r_count == LAST_COUNT) r_state <= CMP;
          end
        end
        CMP: begin
          if (bus.abort) begin
            r_pass  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_pass  <= (w_sig == bus.golden_sig);
            r_state <= DONE;
          end
        end
        DONE: begin
          if (r_start) begin
            r_pass  <= 1'b0;
            r_state <= INIT;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.lfsr_clr  = (r_state == INIT);
  assign bus.lfsr_enb  = (r_state == RUN);
  assign bus.busy      = (r_state == INIT) || (r_state == RUN) || (r_state == CMP);
  assign bus.done      = (r_state == DONE);
  assign bus.pass      = r_pass;
  assign bus.signature = w_sig;
  assign bus.state     = r_state;

endmodule
